frame_collect: RTL and testbench

//  Downstream stage of the zero-padded block inserter. Consumes its 32-cycle frames:

---
 rtl/frame_collect.sv | 212 +++++++++++++++++++++
 tb/tb_frame_collect.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_collect.sv
// Zero-padded frame collector: drops the zero-fill half of each 2*BLK-cycle frame, buffers
// the payload in a two-bank ping-pong RAM and replays each block on a valid/ready stream.
module frame_collect #(
    parameter int unsigned DW  = 16,
    parameter int unsigned BLK = 16,
    parameter int unsigned AW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sof_i,
    input  logic [DW-1:0] d_i,
    input  logic [DW-1:0] d_q,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_i,
    output logic [DW-1:0] m_q,
    output logic [AW-1:0] m_idx,
    output logic          m_last,
    output logic          ovf,
    output logic          zerr
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [AW:0]   LastPos = (AW+1)'(2 * BLK - 1);
    localparam logic [AW-1:0] LastIdx = AW'(BLK - 1);

    state_e          state_q, state_d;
    logic [AW:0]     pos_q, pos_d;
    logic            cap_q, cap_d;
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic [1:0]      full_q, full_d;
    logic            ovf_q, ovf_d;
    logic            zerr_q, zerr_d;
    logic            m_valid_q, m_valid_d;
    logic [DW-1:0]   m_i_q, m_i_d;
    logic [DW-1:0]   m_q_q, m_q_d;
    logic [AW-1:0]   m_idx_q, m_idx_d;
    logic            m_last_q, m_last_d;

    logic [2*DW-1:0] mem_q [2][BLK];

    logic            active;
    logic [AW:0]     cur_pos;
    logic            cap_now;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            full_set;
    logic            full_clr;
    logic            rd_load;
    logic            rd_bank;
    logic [AW-1:0]   rd_addr;
    logic [2*DW-1:0] rd_word;

    // Write FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM: next state
    always_comb begin
        state_d = state_q;
        if (state_q == StIdle && sof_i) begin
            state_d = StRun;
        end
    end

    // Write FSM: outputs. A sof always forces the current position to 0.
    always_comb begin
        active  = (state_q == StRun) || sof_i;
        cur_pos = sof_i ? '0 : pos_q;
    end

    always_comb begin
        pos_d    = pos_q;
        cap_d    = cap_q;
        cap_now  = 1'b0;
        wbank_d  = wbank_q;
        ovf_d    = ovf_q;
        zerr_d   = zerr_q;
        wr_en    = 1'b0;
        wr_addr  = cur_pos[AW-1:0];
        full_set = 1'b0;
        if (active) begin
            pos_d = cur_pos + 1'b1;
            // Acceptance uses the registered full flag, so a bank freed this edge still drops.
            if (cur_pos == '0) begin
                cap_now = !full_q[wbank_q];
                if (full_q[wbank_q]) begin
                    ovf_d = 1'b1;
                end
            end else begin
                cap_now = cap_q;
            end
            cap_d = cap_now;
            if (cap_now) begin
                if (!cur_pos[AW]) begin
                    if (d_i != '0 || d_q != '0) begin
                        zerr_d = 1'b1;
                    end
                end else begin
                    wr_en = 1'b1;
                end
                if (cur_pos == LastPos) begin
                    full_set = 1'b1;
                    wbank_d  = ~wbank_q;
                end
            end
        end
    end

    always_comb begin
        rd_load  = 1'b0;
        rd_bank  = rbank_q;
        rd_addr  = '0;
        rbank_d  = rbank_q;
        full_clr = 1'b0;
        if (!m_valid_q) begin
            rd_load = full_q[rbank_q];
        end else if (m_ready) begin
            if (m_last_q) begin
                full_clr = 1'b1;
                rbank_d  = ~rbank_q;
                rd_bank  = ~rbank_q;
                rd_load  = full_q[~rbank_q];
            end else begin
                rd_load = 1'b1;
                rd_addr = m_idx_q + 1'b1;
            end
        end
    end

    assign rd_word = mem_q[rd_bank][rd_addr];

    always_comb begin
        m_valid_d = m_valid_q;
        m_i_d     = m_i_q;
        m_q_d     = m_q_q;
        m_idx_d   = m_idx_q;
        m_last_d  = m_last_q;
        if (rd_load) begin
            m_valid_d = 1'b1;
            m_i_d     = rd_word[2*DW-1:DW];
            m_q_d     = rd_word[DW-1:0];
            m_idx_d   = rd_addr;
            m_last_d  = (rd_addr == LastIdx);
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Set and clear always target different banks, so both apply together.
    always_comb begin
        full_d = full_q;
        if (full_set) begin
            full_d[wbank_q] = 1'b1;
        end
        if (full_clr) begin
            full_d[rbank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q     <= '0;
            cap_q     <= 1'b0;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            full_q    <= '0;
            ovf_q     <= 1'b0;
            zerr_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_i_q     <= '0;
            m_q_q     <= '0;
            m_idx_q   <= '0;
            m_last_q  <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            cap_q     <= cap_d;
            wbank_q   <= wbank_d;
            rbank_q   <= rbank_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            zerr_q    <= zerr_d;
            m_valid_q <= m_valid_d;
            m_i_q     <= m_i_d;
            m_q_q     <= m_q_d;
            m_idx_q   <= m_idx_d;
            m_last_q  <= m_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wbank_q][wr_addr] <= {d_i, d_q};
        end
    end

    assign m_valid = m_valid_q;
    assign m_i     = m_i_q;
    assign m_q     = m_q_q;
    assign m_idx   = m_idx_q;
    assign m_last  = m_last_q;
    assign ovf     = ovf_q;
    assign zerr    = zerr_q;

endmodule

// File: tb/tb_frame_collect.sv
// Directed bench for frame_collect: frames are driven cycle by cycle and every stream
// handshake is logged, then each scenario task compares the log against expected blocks.
module tb_frame_collect;

    logic        clk = 1'b0;
    logic        reset;
    logic        sof_i;
    logic [15:0] d_i;
    logic [15:0] d_q;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_i;
    logic [15:0] m_q;
    logic [3:0]  m_idx;
    logic        m_last;
    logic        ovf;
    logic        zerr;

    frame_collect #(
        .DW  (16),
        .BLK (16),
        .AW  (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sof_i   (sof_i),
        .d_i     (d_i),
        .d_q     (d_q),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_i     (m_i),
        .m_q     (m_q),
        .m_idx   (m_idx),
        .m_last  (m_last),
        .ovf     (ovf),
        .zerr    (zerr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_edge_cyc = 0;
    int toggle_mode   = 0;
    int stall_viol    = 0;

    logic [31:0] got_data [$];
    logic [3:0]  got_idx  [$];
    logic        got_last [$];
    int          got_cyc  [$];

    logic        pv, pr, plast;
    logic [15:0] pi, pq;
    logic [3:0]  pidx;

    always @(posedge clk) cyc <= cyc + 1;

    // A beat seen valid&&ready at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            if (pv && !pr && (!m_valid || m_i !== pi || m_q !== pq || m_idx !== pidx ||
                              m_last !== plast)) begin
                stall_viol++;
            end
            if (m_valid && m_ready) begin
                got_data.push_back({m_i, m_q});
                got_idx.push_back(m_idx);
                got_last.push_back(m_last);
                got_cyc.push_back(cyc);
            end
            pv = m_valid;
        end else begin
            pv = 1'b0;
        end
        pr = m_ready; pi = m_i; pq = m_q; pidx = m_idx; plast = m_last;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] exp_word(input logic [15:0] ib, input logic [15:0] qb,
                                             input int k);
        logic [15:0] wi;
        logic [15:0] wq;
        wi = ib + 16'(k + 1);
        wq = qb + 16'(k + 1);
        return {wi, wq};
    endfunction

    task automatic clear_log();
        got_data.delete();
        got_idx.delete();
        got_last.delete();
        got_cyc.delete();
        stall_viol = 0;
    endtask

    task automatic drive_cycle(input logic sof, input logic [15:0] di, input logic [15:0] dq,
                               input int p);
        sof_i = sof;
        d_i   = di;
        d_q   = dq;
        if (toggle_mode != 0) m_ready = (p % 2 == 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [15:0] ib, input logic [15:0] qb, input int bad_pos,
                             input int ncyc);
        for (int p = 0; p < ncyc; p++) begin
            if (p < 16) drive_cycle(p == 0, (p == bad_pos) ? 16'h0005 : 16'h0000, 16'h0000, p);
            else        drive_cycle(p == 0, ib + 16'(p - 15), qb + 16'(p - 15), p);
        end
        last_edge_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 16'h0000, 16'h0000, i);
    endtask

    task automatic do_reset(input logic rdy, input int tog);
        toggle_mode = tog;
        reset   = 1'b0;
        sof_i   = 1'b0;
        d_i     = '0;
        d_q     = '0;
        m_ready = rdy;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        reset = 1'b0; sof_i = 1'b0; d_i = '0; d_q = '0; m_ready = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_i, m_q, m_idx, m_last, ovf, zerr} !== 40'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {m_valid, m_i, m_q, m_idx, m_last, ovf, zerr});
        end
    endtask

    task automatic test_basic();
        do_reset(1'b1, 0);
        idle(3);
        run_frame(16'h0000, 16'h8000, -1, 32);
        idle(20);
        checks++;
        if (got_data.size() != 16) begin
            failures++;
            $display("FAIL basic_count: got %0d beats expected 16", got_data.size());
        end
        for (int k = 0; k < got_data.size() && k < 16; k++) begin
            checks++;
            if (got_data[k] !== exp_word(16'h0000, 16'h8000, k) || got_idx[k] !== 4'(k) ||
                got_last[k] !== (k == 15) || got_cyc[k] != last_edge_cyc + 1 + k) begin
                failures++;
                $display("FAIL basic_beat%0d: got %h idx %0d last %0b cyc %0d expected %h idx %0d last %0b cyc %0d",
                         k, got_data[k], got_idx[k], got_last[k], got_cyc[k],
                         exp_word(16'h0000, 16'h8000, k), k, (k == 15), last_edge_cyc + 1 + k);
            end
        end
        checks++;
        if (ovf !== 1'b0 || zerr !== 1'b0) begin
            failures++;
            $display("FAIL basic_flags: got ovf %0b zerr %0b expected 0 0", ovf, zerr);
        end
    endtask

    task automatic test_toggle();
        do_reset(1'b0, 1);
        for (int f = 0; f < 4; f++) run_frame(16'(16'h0100 * (f + 1)),
                                              16'(16'h4000 + 16'h0100 * (f + 1)), -1, 32);
        idle(33);
        checks++;
        if (got_data.size() != 64) begin
            failures++;
            $display("FAIL toggle_count: got %0d beats expected 64", got_data.size());
        end
        for (int k = 0; k < got_data.size() && k < 64; k++) begin
            checks++;
            if (got_data[k] !== exp_word(16'(16'h0100 * (k / 16 + 1)),
                                         16'(16'h4000 + 16'h0100 * (k / 16 + 1)), k % 16) ||
                got_idx[k] !== 4'(k % 16) || got_last[k] !== (k % 16 == 15)) begin
                failures++;
                $display("FAIL toggle_beat%0d: got %h idx %0d last %0b expected %h idx %0d",
                         k, got_data[k], got_idx[k], got_last[k],
                         exp_word(16'(16'h0100 * (k / 16 + 1)),
                                  16'(16'h4000 + 16'h0100 * (k / 16 + 1)), k % 16), k % 16);
            end
        end
        checks++;
        if (stall_viol != 0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL toggle_stable: got %0d stall changes ovf %0b expected 0 0",
                     stall_viol, ovf);
        end
    endtask

    task automatic test_overflow();
        do_reset(1'b0, 0);
        for (int f = 0; f < 3; f++) run_frame(16'(16'h1000 * (f + 1)), 16'(16'h2000 + f), -1, 32);
        checks++;
        if (ovf !== 1'b1 || got_data.size() != 0) begin
            failures++;
            $display("FAIL ovf_flag: got ovf %0b beats %0d expected 1 0", ovf, got_data.size());
        end
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 4'd0 || {m_i, m_q} !== exp_word(16'h1000, 16'h2000, 0))
        begin
            failures++;
            $display("FAIL ovf_hold: got v %0b idx %0d data %h expected 1 0 %h", m_valid, m_idx,
                     {m_i, m_q}, exp_word(16'h1000, 16'h2000, 0));
        end
        m_ready = 1'b1;
        idle(40);
        checks++;
        if (got_data.size() != 32) begin
            failures++;
            $display("FAIL ovf_count: got %0d beats expected 32", got_data.size());
        end
        for (int k = 0; k < got_data.size() && k < 32; k++) begin
            checks++;
            if (got_data[k] !== exp_word(16'(16'h1000 * (k / 16 + 1)), 16'(16'h2000 + k / 16),
                                         k % 16) || got_idx[k] !== 4'(k % 16)) begin
                failures++;
                $display("FAIL ovf_beat%0d: got %h idx %0d expected %h idx %0d", k, got_data[k],
                         got_idx[k], exp_word(16'(16'h1000 * (k / 16 + 1)),
                                              16'(16'h2000 + k / 16), k % 16), k % 16);
            end
        end
    endtask

    task automatic test_zerr();
        do_reset(1'b1, 0);
        run_frame(16'h3300, 16'h7700, 7, 32);
        idle(20);
        checks++;
        if (zerr !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL zerr_flag: got zerr %0b ovf %0b expected 1 0", zerr, ovf);
        end
        checks++;
        if (got_data.size() != 16) begin
            failures++;
            $display("FAIL zerr_count: got %0d beats expected 16", got_data.size());
        end
        for (int k = 0; k < got_data.size() && k < 16; k++) begin
            checks++;
            if (got_data[k] !== exp_word(16'h3300, 16'h7700, k) || got_last[k] !== (k == 15)) begin
                failures++;
                $display("FAIL zerr_beat%0d: got %h last %0b expected %h", k, got_data[k],
                         got_last[k], exp_word(16'h3300, 16'h7700, k));
            end
        end
    endtask

    task automatic test_resync();
        do_reset(1'b1, 0);
        run_frame(16'h5500, 16'h6600, -1, 20);
        run_frame(16'hA000, 16'hB000, -1, 32);
        idle(20);
        checks++;
        if (got_data.size() != 16) begin
            failures++;
            $display("FAIL resync_count: got %0d beats expected 16", got_data.size());
        end
        for (int k = 0; k < got_data.size() && k < 16; k++) begin
            checks++;
            if (got_data[k] !== exp_word(16'hA000, 16'hB000, k) || got_idx[k] !== 4'(k) ||
                got_cyc[k] != last_edge_cyc + 1 + k) begin
                failures++;
                $display("FAIL resync_beat%0d: got %h idx %0d cyc %0d expected %h idx %0d cyc %0d",
                         k, got_data[k], got_idx[k], got_cyc[k], exp_word(16'hA000, 16'hB000, k),
                         k, last_edge_cyc + 1 + k);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset(1'b1, 0);
        run_frame(16'hC000, 16'hD000, -1, 32);
        sof_i = 1'b0; d_i = '0; d_q = '0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (m_valid && m_idx == 4'd9) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rstmid_reach: got no beat idx 9 within 40 cycles expected one");
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_i, m_q, m_idx, m_last, ovf, zerr} !== 40'h0) begin
            failures++;
            $display("FAIL rstmid_outputs: got %0h expected 0",
                     {m_valid, m_i, m_q, m_idx, m_last, ovf, zerr});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_log();
        idle(70);
        checks++;
        if (got_data.size() != 0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet: got %0d beats valid %0b expected 0 0", got_data.size(),
                     m_valid);
        end
        run_frame(16'hE000, 16'hF000, -1, 32);
        idle(20);
        checks++;
        if (got_data.size() != 16) begin
            failures++;
            $display("FAIL rstmid_count: got %0d beats expected 16", got_data.size());
        end
        for (int k = 0; k < got_data.size() && k < 16; k++) begin
            checks++;
            if (got_data[k] !== exp_word(16'hE000, 16'hF000, k) || got_idx[k] !== 4'(k)) begin
                failures++;
                $display("FAIL rstmid_beat%0d: got %h idx %0d expected %h idx %0d", k,
                         got_data[k], got_idx[k], exp_word(16'hE000, 16'hF000, k), k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_overflow();
        test_zerr();
        test_resync();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
